// File: rtl/systolic_feeder.sv
// Skew feeder: buffers one K x N operand tile, then streams it diagonally into the PE array edge.
// Optional ping-pong buffering under `SYSTOLIC_FEEDER_DOUBLE_BUF_EN`.

module systolic_feeder_lane #(
  parameter int K    = 4,
  parameter int W    = 32,
  parameter int CW   = 3,
  parameter int LANE = 0
) (
  input  logic [K-1:0][W-1:0] col,
  input  logic [CW-1:0]       step,
  output logic [W-1:0]        val
);
  // lane LANE carries element k at step k+LANE; every other step is +0.0 padding
  always_comb begin
    val = '0;
    for (int k = 0; k < K; k++)
      if (step == CW'(k + LANE)) val = col[k];
  end
endmodule

module systolic_feeder #(
  parameter int N = 4,
  parameter int K = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           hold,
  output logic [N*W-1:0] out_a,
  output logic           out_valid,
  output logic           busy,
  output logic           done
);
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam int NB = DBUF ? 2 : 1;
  localparam int CW = $clog2(K + N);
  localparam logic [CW-1:0] LAST_T = CW'(K + N - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  typedef logic [K-1:0][N-1:0][W-1:0] tile_t;

  logic [1:0]    state;
  logic [CW-1:0] fill, t, emit_t;
  logic          cur, wbank, pend;
  tile_t [NB-1:0] mem, mem_nxt;
  tile_t         tile_sel;
  logic [N-1:0][W-1:0] step_val;

  logic rdy_int, acc, fill_last, stream_end, chain, launch, emit, emit_bank;

  always_comb begin
    rdy_int = 1'b0;
    unique case (state)
      S_IDLE, S_FILL: rdy_int = 1'b1;
      S_STREAM:       rdy_int = DBUF && !pend;
      default:        rdy_int = 1'b0;
    endcase
  end

  assign in_ready   = rst && rdy_int;
  assign acc        = in_valid && in_ready;
  assign fill_last  = acc && (fill == CW'(K - 1));
  assign stream_end = (state == S_STREAM) && !hold && (t == LAST_T);
  // a completed back bank (already pending or finishing now) starts with zero bubble
  assign chain      = stream_end && (pend || fill_last);
  assign launch     = ((state != S_STREAM) && fill_last) || chain;
  assign emit       = launch || ((state == S_STREAM) && !hold && (t != LAST_T));
  assign emit_bank  = launch ? wbank : cur;
  assign emit_t     = launch ? '0 : t;
  assign busy       = (state != S_IDLE);

  // write-through view so the launching edge can already drive step 0
  always_comb begin
    mem_nxt = mem;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < K; k++)
        if (acc && (wbank == 1'(b)) && (fill == CW'(k))) mem_nxt[b][k] = in_data;
  end

  always_comb begin
    tile_sel = mem_nxt[0];
    for (int b = 0; b < NB; b++)
      if (emit_bank == 1'(b)) tile_sel = mem_nxt[b];
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [K-1:0][W-1:0] col;
    for (genvar k = 0; k < K; k++) begin : g_k
      assign col[k] = tile_sel[k][i];
    end
    systolic_feeder_lane #(.K(K), .W(W), .CW(CW), .LANE(i)) u_lane (
      .col  (col),
      .step (emit_t),
      .val  (step_val[i])
    );
  end

  always_ff @(posedge clk) mem <= mem_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      fill      <= '0;
      t         <= '0;
      cur       <= 1'b0;
      wbank     <= 1'b0;
      pend      <= 1'b0;
      out_a     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= stream_end;
      out_valid <= emit;
      if (emit)            out_a <= step_val;
      else if (stream_end) out_a <= '0;

      if (acc) fill <= fill_last ? '0 : fill + CW'(1);

      if (chain)                                  pend <= 1'b0;
      else if ((state == S_STREAM) && fill_last)  pend <= 1'b1;

      if (launch) begin
        cur <= wbank;
        if (DBUF) wbank <= ~wbank;
      end

      if (launch)                                       t <= CW'(1);
      else if ((state == S_STREAM) && !hold && !stream_end) t <= t + CW'(1);

      if (launch)                      state <= S_STREAM;
      else if (stream_end)             state <= ((fill != '0) || acc) ? S_FILL : S_IDLE;
      else if ((state == S_IDLE) && acc) state <= S_FILL;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4,K=4 main instance, N=1,K=1 corner instance).
module tb_systolic_feeder;
  localparam int N = 4, K = 4, W = 32, STEPS = K + N - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_ready, hold, out_valid, busy, done;
  logic [N*W-1:0] in_data, out_a;
  logic           in_valid1, in_ready1, hold1, out_valid1, busy1, done1;
  logic [W-1:0]   in_data1, out_a1;

  logic [W-1:0]   tiles [2][K][N];
  logic [N*W-1:0] cap [STEPS];
  int checks = 0, failures = 0, acc_cnt = 0;

  systolic_feeder #(.N(N), .K(K), .W(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold(hold), .out_a(out_a), .out_valid(out_valid), .busy(busy), .done(done)
  );

  systolic_feeder #(.N(1), .K(1), .W(W)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .hold(hold1), .out_a(out_a1), .out_valid(out_valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (in_valid && in_ready) acc_cnt++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] vec(input int tid, input int k);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = tiles[tid][k][i];
    return r;
  endfunction

  // lane i at step s carries element (i, s-i) when that index exists, else +0.0
  function automatic logic [N*W-1:0] step_ref(input int tid, input int s);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (s - i >= 0 && s - i < K) r[i*W +: W] = tiles[tid][s-i][i];
    return r;
  endfunction

  task automatic load_tile(input int tid, input bit gaps);
    for (int k = 0; k < K; k++) begin
      if (gaps && k > 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1;
      in_data  = vec(tid, k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // called in the cycle showing step 0; hold inserts hold_len bubbles after step hold_at
  task automatic run_stream(input int tid, input int hold_at, input int hold_len,
                            input bit chk_rdy, input string tg);
    int ev[$];
    int es[$];
    for (int s = 0; s < STEPS; s++) begin
      ev.push_back(1); es.push_back(s);
      if (s == hold_at)
        for (int h = 0; h < hold_len; h++) begin ev.push_back(0); es.push_back(s); end
    end
    ev.push_back(0); es.push_back(-1);
    for (int c = 0; c < ev.size(); c++) begin
      chk({tg, "_vld"},  out_valid, ev[c]);
      chk({tg, "_dat"},  out_a, (es[c] < 0) ? '0 : step_ref(tid, es[c]));
      chk({tg, "_done"}, done, es[c] < 0);
      chk({tg, "_busy"}, busy, es[c] >= 0);
      if (ev[c] == 1) cap[es[c]] = out_a;
      if (chk_rdy && es[c] >= 0) chk({tg, "_rdy"}, in_ready, 1'b0);
      if (es[c] < 0) begin
        in_valid = 1'b0;
        hold     = 1'b0;
      end else begin
        hold = (c + 1 < ev.size()) && (ev[c+1] == 0) && (es[c+1] >= 0);
      end
      tick();
    end
    chk({tg, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; hold = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_data1 = '0; hold1 = 1'b0;
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        tiles[0][k][i] = 32'h10 * i + k;
        tiles[1][k][i] = 32'h3F800000;
      end

    tick(); tick();
    chk("rst_rdy",  in_ready,  1'b0);
    chk("rst_vld",  out_valid, 1'b0);
    chk("rst_dat",  out_a,     '0);
    chk("rst_busy", busy,      1'b0);
    chk("rst_done", done,      1'b0);
    rst = 1'b1;
    tick();
    chk("rel_rdy",  in_ready,  1'b1);
    chk("rel_busy", busy,      1'b0);

    // skew pattern
    load_tile(0, 1'b0);
    run_stream(0, -1, 0, 1'b0, "skew");
    chk("skew_s0", cap[0], 128'h0);
    chk("skew_s3", cap[3], 128'h00000030_00000021_00000012_00000003);
    chk("skew_s6", cap[6], 128'h00000033_00000000_00000000_00000000);

    // hold mid-stream and hold on the final step
    load_tile(0, 1'b0);
    run_stream(0, 2, 3, 1'b0, "hold");
    load_tile(0, 1'b0);
    run_stream(0, STEPS - 1, 2, 1'b0, "hold_last");

    // producer backpressure: gapped fill, then in_valid held high while streaming
    acc_cnt = 0;
    load_tile(0, 1'b1);
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    in_valid = 1'b1;
    in_data  = {N{32'hBAD0BAD0}};
    run_stream(0, -1, 0, 1'b1, "bp");
`else
    run_stream(0, -1, 0, 1'b0, "bp");
`endif
    chk("bp_accepts", acc_cnt, K);

    // reset while showing step 3
    load_tile(0, 1'b0);
    tick(); tick(); tick();
    chk("mid_s3", out_a, step_ref(0, 3));
    rst = 1'b0;
    tick();
    chk("mrst_vld",  out_valid, 1'b0);
    chk("mrst_dat",  out_a,     '0);
    chk("mrst_done", done,      1'b0);
    chk("mrst_busy", busy,      1'b0);
    chk("mrst_rdy",  in_ready,  1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_nodone", done,     1'b0);
    chk("mrst_rdy1",   in_ready, 1'b1);
    load_tile(1, 1'b0);
    run_stream(1, -1, 0, 1'b0, "ones");

    // K=1, N=1 corner
    chk("k1_rdy", in_ready1, 1'b1);
    in_valid1 = 1'b1;
    in_data1  = 32'hDEADBEEF;
    tick();
    in_valid1 = 1'b0;
    chk("k1_vld",  out_valid1, 1'b1);
    chk("k1_dat",  out_a1,     32'hDEADBEEF);
    chk("k1_done", done1,      1'b0);
    tick();
    chk("k1_vld_end",  out_valid1, 1'b0);
    chk("k1_done_end", done1,      1'b1);
    chk("k1_dat_end",  out_a1,     32'h0);
    tick();
    chk("k1_done_clr", done1, 1'b0);

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    begin
      logic           ov [48];
      logic           od [48];
      logic [N*W-1:0] oa [48];
      int vi, first;
      vi = 0; first = -1;
      in_valid = 1'b1;
      in_data  = vec(0, 0);
      for (int c = 0; c < 48; c++) begin
        if (in_valid && in_ready) vi++;
        tick();
        if (vi < 2*K) in_data = vec(vi / K, vi % K);
        else          in_valid = 1'b0;
        ov[c] = out_valid; od[c] = done; oa[c] = out_a;
        if (out_valid && first < 0) first = c;
      end
      chk("db_start", first >= 0 && first + 2*STEPS < 48, 1'b1);
      if (first >= 0 && first + 2*STEPS < 48) begin
        for (int j = 0; j < 2*STEPS; j++) begin
          chk("db_vld",  ov[first+j], 1'b1);
          chk("db_dat",  oa[first+j], step_ref(j / STEPS, j % STEPS));
          chk("db_done", od[first+j], j == STEPS);
        end
        chk("db_end_done", od[first+2*STEPS], 1'b1);
        chk("db_end_vld",  ov[first+2*STEPS], 1'b0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
